syn_av_mm_arb: RTL and testbench
================================

Name: syn_av_mm_arb

Overview:
- Round-robin arbiter sharing one Avalon MM slave port between NUM_MST requesters, e.g. the codec config sequencer, the debug host bridge and the FFT coefficient loader.
- Slave side uses the codebase's no-waitrequest Avalon MM signal set: the slave accepts every command in the cycle it is presented.
- Read responses return in order, with variable latency. The arbiter tags every issued read and routes its data back to the requester that issued it.

Parameters:
- NUM_MST, 3, number of requesters (2..8)
- ADDR_W, 12, address width
- DATA_W, 32, data width
- MAX_RD, 4, maximum outstanding reads; depth of the read-tag FIFO (power of 2)
- ID_W, $clog2(NUM_MST), localparam, requester tag width

Ports:
- av_clk  in  1  clock; all logic on rising edge
- av_rst  in  1  asynchronous, active-high reset
- mst_read  in  NUM_MST  per-requester read request
- mst_write  in  NUM_MST  per-requester write request
- mst_addr  in  NUM_MST*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
- mst_write_data  in  NUM_MST*DATA_W  packed write data
- mst_ack  out  NUM_MST  one-cycle pulse: command of requester i issued this cycle
- mst_read_data  out  DATA_W  shared read-return data
- mst_rd_data_valid  out  NUM_MST  one-hot; mst_read_data belongs to requester i
- av_read  out  1  slave read strobe
- av_write  out  1  slave write strobe
- av_addr  out  ADDR_W  slave address
- av_write_data  out  DATA_W  slave write data
- av_read_data  in  DATA_W  slave read data
- av_rd_data_valid  in  1  slave read data valid
- rd_underflow_err  out  1  sticky: av_rd_data_valid arrived with no read outstanding

Behaviour:
- Reset: all outputs 0, tag FIFO empty, rd_count = 0, last_grant = NUM_MST-1 (requester 0 has first priority).
- Request:
  - req[i] = mst_read[i] | mst_write[i], masked by mst_ack[i].
  - An acked requester is therefore ineligible in the ack cycle; it must drop or replace its request at the end of that cycle.
  - Requests and their addr/data are held stable until ack.
- Read eligibility: a read request is eligible only if rd_count < MAX_RD. Writes are never blocked.
- Both mst_read[i] and mst_write[i] high: treated as a write; the read is ignored (bench flags a protocol error).
- Arbitration:
  - Combinational, in cycle t: pick the first eligible requester searching last_grant+1, +2, ... modulo NUM_MST.
  - At the next edge, register av_read/av_write/av_addr/av_write_data from the winner, pulse mst_ack[winner] and update last_grant. Latency is 1 cycle from request to slave strobe.
  - No eligible request: av_read = av_write = 0; av_addr/av_write_data hold their last values.
- Throughput:
  - One command per cycle across requesters.
  - At most one command per 2 cycles per requester.
  - av_read and av_write are never both high.
- Read tagging:
  - Push the winner's ID into the tag FIFO in the same edge that asserts av_read.
  - On av_rd_data_valid, pop the head; at the next edge drive mst_read_data = av_read_data and mst_rd_data_valid[head] = 1 for one cycle. Read-return latency is 1 cycle.
- Simultaneous push and pop: rd_count is unchanged; a read may be issued in the cycle the FIFO was full if a pop occurs in the same cycle (eligibility uses rd_count < MAX_RD || av_rd_data_valid).
- Underflow: av_rd_data_valid with rd_count == 0 produces no mst_rd_data_valid and sets rd_underflow_err. It is cleared only by reset.
- Reset mid-operation: outstanding tags are discarded. Responses arriving after reset are underflows; the bench expects rd_underflow_err = 1.
- rd_count range: 0..MAX_RD. FIFO pointers wrap modulo MAX_RD.

Test Plan:
- Reset, then requester 1 writes addr 0x010, data 0xDEADBEEF. Required: mst_ack[1] 1 cycle later; av_write=1, av_addr=0x010, av_write_data=0xDEADBEEF in the same cycle; no other strobe.
- Requesters 0, 1 and 2 all hold write requests continuously for 6 grants. Required: grant order 0,1,2,0,1,2; av_write high every cycle; no double issue of any requester.
- Requester 0 reads 0x004 and requester 2 reads 0x008 back-to-back; slave returns 0x11 after 3 cycles, then 0x22 after 5 cycles. Required: mst_rd_data_valid=3'b001 with data 0x11, then 3'b100 with data 0x22, each 1 cycle after the slave valid.
- MAX_RD=4; issue 4 reads with no response, requester 1 then requests a read and requester 2 a write. Required: write is granted, read is stalled; first av_rd_data_valid lets the read issue in that same cycle; rd_count never exceeds 4.
- av_rd_data_valid pulsed with nothing outstanding. Required: no mst_rd_data_valid; rd_underflow_err=1 and it stays set.
- 2 reads outstanding, assert av_rst for 1 cycle, then the slave returns 2 responses. Required: all outputs 0 during reset; no mst_rd_data_valid afterwards; rd_underflow_err=1; requester 0 wins the first post-reset contention.

Source files
------------

// File: rtl/syn_av_mm_arb.sv
// Round-robin arbiter that shares one no-waitrequest Avalon MM slave between NUM_MST requesters.
// Read responses return in order; a tag FIFO routes each response back to the requester that issued the read.
module syn_av_mm_arb #(
   parameter int NUM_MST = 3,
   parameter int ADDR_W  = 12,
   parameter int DATA_W  = 32,
   parameter int MAX_RD  = 4
) (
   input  logic                        av_clk,
   input  logic                        av_rst,
   input  logic [NUM_MST-1:0]          mst_read,
   input  logic [NUM_MST-1:0]          mst_write,
   input  logic [NUM_MST*ADDR_W-1:0]   mst_addr,
   input  logic [NUM_MST*DATA_W-1:0]   mst_write_data,
   output logic [NUM_MST-1:0]          mst_ack,
   output logic [DATA_W-1:0]           mst_read_data,
   output logic [NUM_MST-1:0]          mst_rd_data_valid,
   output logic                        av_read,
   output logic                        av_write,
   output logic [ADDR_W-1:0]           av_addr,
   output logic [DATA_W-1:0]           av_write_data,
   input  logic [DATA_W-1:0]           av_read_data,
   input  logic                        av_rd_data_valid,
   output logic                        rd_underflow_err
);

   localparam int ID_W  = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;
   localparam int PTR_W = (MAX_RD > 1) ? $clog2(MAX_RD) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] RD_LIM = CNT_W'(MAX_RD);

   logic [NUM_MST-1:0] req_p0;
   logic [NUM_MST-1:0] elig_p0;
   logic [NUM_MST-1:0] grant_oh_p0;
   logic               found_p0;
   logic               sel_wr_p0;
   logic [ID_W-1:0]    win_p0;
   logic [ADDR_W-1:0]  sel_addr_p0;
   logic [DATA_W-1:0]  sel_wdata_p0;

   logic               rd_ok;
   logic               push;
   logic               pop;
   logic [ID_W-1:0]    last_grant;
   logic [ID_W-1:0]    tag_mem [MAX_RD];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [CNT_W-1:0]   rd_count;
   logic [NUM_MST-1:0] head_oh;

   // A response popping this cycle frees a slot, so a read may issue even when the FIFO is full.
   assign rd_ok   = (rd_count < RD_LIM) || av_rd_data_valid;
   assign req_p0  = (mst_read | mst_write) & ~mst_ack;
   assign elig_p0 = req_p0 & (mst_write | {NUM_MST{rd_ok}});

   always_comb begin
      found_p0     = 1'b0;
      sel_wr_p0    = 1'b0;
      win_p0       = '0;
      grant_oh_p0  = '0;
      sel_addr_p0  = '0;
      sel_wdata_p0 = '0;
      for (int k = 1; k <= NUM_MST; k++) begin
         for (int i = 0; i < NUM_MST; i++) begin
            if (!found_p0 && elig_p0[i] && (i == (int'(last_grant) + k) % NUM_MST)) begin
               found_p0       = 1'b1;
               win_p0         = ID_W'(i);
               grant_oh_p0[i] = 1'b1;
               sel_wr_p0      = mst_write[i];
               sel_addr_p0    = mst_addr[i*ADDR_W +: ADDR_W];
               sel_wdata_p0   = mst_write_data[i*DATA_W +: DATA_W];
            end
         end
      end
   end

   assign push = found_p0 & ~sel_wr_p0;
   assign pop  = av_rd_data_valid & (rd_count != '0);

   always_comb begin
      head_oh = '0;
      for (int i = 0; i < NUM_MST; i++)
         head_oh[i] = (tag_mem[rd_ptr] == ID_W'(i));
   end

   always_ff @(posedge av_clk) begin
      if (push)
         tag_mem[wr_ptr] <= win_p0;
   end

   always_ff @(posedge av_clk or posedge av_rst) begin
      if (av_rst) begin
         mst_ack           <= '0;
         mst_read_data     <= '0;
         mst_rd_data_valid <= '0;
         av_read           <= 1'b0;
         av_write          <= 1'b0;
         av_addr           <= '0;
         av_write_data     <= '0;
         rd_underflow_err  <= 1'b0;
         last_grant        <= ID_W'(NUM_MST - 1);
         wr_ptr            <= '0;
         rd_ptr            <= '0;
         rd_count          <= '0;
      end else begin
         // issue stage: register the winner onto the slave port
         av_read  <= push;
         av_write <= found_p0 & sel_wr_p0;
         mst_ack  <= grant_oh_p0;
         if (found_p0) begin
            av_addr       <= sel_addr_p0;
            av_write_data <= sel_wdata_p0;
            last_grant    <= win_p0;
         end
         if (push)
            wr_ptr <= wr_ptr + PTR_W'(1);

         // return stage: route the slave response to the tagged requester
         mst_rd_data_valid <= pop ? head_oh : '0;
         if (pop) begin
            mst_read_data <= av_read_data;
            rd_ptr        <= rd_ptr + PTR_W'(1);
         end
         if (av_rd_data_valid && (rd_count == '0))
            rd_underflow_err <= 1'b1;

         case ({push, pop})
            2'b10:   rd_count <= rd_count + CNT_W'(1);
            2'b01:   rd_count <= rd_count - CNT_W'(1);
            default: rd_count <= rd_count;
         endcase
      end
   end

endmodule

// File: tb/tb_syn_av_mm_arb.sv
// Scoreboard bench for syn_av_mm_arb: directed stimulus pushes expected commands/responses,
// a negedge monitor pops and compares whenever the DUT strobes the slave or returns read data.
module tb_syn_av_mm_arb;

   localparam int NM = 3;
   localparam int AW = 12;
   localparam int DW = 32;

   logic             av_clk;
   logic             av_rst;
   logic [NM-1:0]    mst_read;
   logic [NM-1:0]    mst_write;
   logic [NM*AW-1:0] mst_addr;
   logic [NM*DW-1:0] mst_write_data;
   logic [NM-1:0]    mst_ack;
   logic [DW-1:0]    mst_read_data;
   logic [NM-1:0]    mst_rd_data_valid;
   logic             av_read;
   logic             av_write;
   logic [AW-1:0]    av_addr;
   logic [DW-1:0]    av_write_data;
   logic [DW-1:0]    av_read_data;
   logic             av_rd_data_valid;
   logic             rd_underflow_err;

   syn_av_mm_arb #(.NUM_MST(NM), .ADDR_W(AW), .DATA_W(DW), .MAX_RD(4)) dut (
      .av_clk            (av_clk),
      .av_rst            (av_rst),
      .mst_read          (mst_read),
      .mst_write         (mst_write),
      .mst_addr          (mst_addr),
      .mst_write_data    (mst_write_data),
      .mst_ack           (mst_ack),
      .mst_read_data     (mst_read_data),
      .mst_rd_data_valid (mst_rd_data_valid),
      .av_read           (av_read),
      .av_write          (av_write),
      .av_addr           (av_addr),
      .av_write_data     (av_write_data),
      .av_read_data      (av_read_data),
      .av_rd_data_valid  (av_rd_data_valid),
      .rd_underflow_err  (rd_underflow_err)
   );

   typedef struct {
      logic          rd;
      logic          wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [NM-1:0] ack;
   } cmd_t;

   typedef struct {
      logic [NM-1:0] vld;
      logic [DW-1:0] data;
   } rsp_t;

   cmd_t cmd_q[$];
   rsp_t rsp_q[$];
   cmd_t ce;
   rsp_t re;
   int   n_vec = 0;
   int   n_err = 0;

   initial av_clk = 1'b0;
   always #5 av_clk = ~av_clk;

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge av_clk);
      #1;
   endtask

   function automatic logic [127:0] all_outs();
      return 128'({mst_ack, mst_read_data, mst_rd_data_valid, av_read, av_write,
                   av_addr, av_write_data, rd_underflow_err});
   endfunction

   task automatic push_cmd(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [NM-1:0] ack);
      cmd_t c;
      c.rd = ~wr; c.wr = wr; c.addr = a; c.wdata = d; c.ack = ack;
      cmd_q.push_back(c);
   endtask

   task automatic push_rsp(input logic [NM-1:0] v, input logic [DW-1:0] d);
      rsp_t r;
      r.vld = v; r.data = d;
      rsp_q.push_back(r);
   endtask

   task automatic apply_reset();
      av_rst = 1'b1;
      #1;
      chk("outs_in_reset", all_outs(), 128'(0));
      tick(1);
      av_rst = 1'b0;
      tick(1);
   endtask

   // Single requester command: raise request, wait (bounded) for ack, drop request.
   task automatic do_cmd(input int id, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
      int t;
      push_cmd(wr, a, d, NM'(1 << id));
      mst_addr[id*AW +: AW]       = a;
      mst_write_data[id*DW +: DW] = d;
      if (wr) mst_write[id] = 1'b1;
      else    mst_read[id]  = 1'b1;
      t = 0;
      do begin
         tick(1);
         t++;
      end while (!mst_ack[id] && t < 20);
      chk("ack_wait", 128'(mst_ack[id]), 128'(1));
      mst_read[id]  = 1'b0;
      mst_write[id] = 1'b0;
   endtask

   task automatic set_all_req_data();
      for (int i = 0; i < NM; i++) begin
         mst_addr[i*AW +: AW]       = AW'(12'h020 + i);
         mst_write_data[i*DW +: DW] = DW'(32'hA000_0000 + i);
      end
   endtask

   // Monitor: compare every slave strobe and every read return against the scoreboard.
   always @(negedge av_clk) begin
      if (av_read || av_write) begin
         if (cmd_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_cmd: got rd=%0b wr=%0b addr=%0h ack=%0b, expected no command",
                     av_read, av_write, av_addr, mst_ack);
         end else begin
            ce = cmd_q.pop_front();
            chk("cmd_rd",   128'(av_read),  128'(ce.rd));
            chk("cmd_wr",   128'(av_write), 128'(ce.wr));
            chk("cmd_addr", 128'(av_addr),  128'(ce.addr));
            chk("cmd_ack",  128'(mst_ack),  128'(ce.ack));
            if (ce.wr) chk("cmd_wdata", 128'(av_write_data), 128'(ce.wdata));
         end
      end else if (mst_ack != '0) begin
         n_vec++; n_err++;
         $display("FAIL ack_without_strobe: got ack=%0b, expected 0", mst_ack);
      end
      if (mst_rd_data_valid != '0) begin
         if (rsp_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_rsp: got vld=%0b data=%0h, expected none",
                     mst_rd_data_valid, mst_read_data);
         end else begin
            re = rsp_q.pop_front();
            chk("rsp_vld",  128'(mst_rd_data_valid), 128'(re.vld));
            chk("rsp_data", 128'(mst_read_data),     128'(re.data));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      av_rst           = 1'b1;
      mst_read         = '0;
      mst_write        = '0;
      mst_addr         = '0;
      mst_write_data   = '0;
      av_read_data     = '0;
      av_rd_data_valid = 1'b0;
      tick(2);
      apply_reset();

      // Single write from requester 1
      push_cmd(1'b1, 12'h010, 32'hDEADBEEF, 3'b010);
      mst_addr[1*AW +: AW]       = 12'h010;
      mst_write_data[1*DW +: DW] = 32'hDEADBEEF;
      mst_write[1]               = 1'b1;
      tick(1);
      chk("t1_ack",   128'(mst_ack),  128'(3'b010));
      chk("t1_write", 128'(av_write), 128'(1));
      chk("t1_read",  128'(av_read),  128'(0));
      mst_write = '0;
      tick(2);

      // Three continuous writers: round-robin 0,1,2,0,1,2
      apply_reset();
      set_all_req_data();
      for (int g = 0; g < 6; g++)
         push_cmd(1'b1, AW'(12'h020 + (g % 3)), DW'(32'hA000_0000 + (g % 3)), NM'(1 << (g % 3)));
      mst_write = 3'b111;
      for (int g = 0; g < 6; g++) begin
         tick(1);
         chk("rr_write_every_cycle", 128'(av_write), 128'(1));
      end
      mst_write = '0;
      tick(2);

      // Back-to-back reads from 0 and 2, returns after 3 and 5 cycles
      mst_addr[0*AW +: AW] = 12'h004;
      mst_addr[2*AW +: AW] = 12'h008;
      push_cmd(1'b0, 12'h004, '0, 3'b001);
      push_cmd(1'b0, 12'h008, '0, 3'b100);
      mst_read = 3'b101;
      tick(1);
      chk("rd0_ack", 128'(mst_ack), 128'(3'b001));
      mst_read[0] = 1'b0;
      tick(1);
      chk("rd2_ack", 128'(mst_ack), 128'(3'b100));
      mst_read[2] = 1'b0;
      tick(1);
      push_rsp(3'b001, 32'h11);
      av_rd_data_valid = 1'b1;
      av_read_data     = 32'h11;
      tick(1);
      chk("rsp0_latency", 128'(mst_rd_data_valid), 128'(3'b001));
      av_rd_data_valid = 1'b0;
      tick(2);
      push_rsp(3'b100, 32'h22);
      av_rd_data_valid = 1'b1;
      av_read_data     = 32'h22;
      tick(1);
      chk("rsp2_latency", 128'(mst_rd_data_valid), 128'(3'b100));
      av_rd_data_valid = 1'b0;
      tick(2);

      // Fill the read FIFO; a read stalls while a write still goes through
      for (int k = 0; k < 4; k++)
         do_cmd(0, 1'b0, AW'(12'h100 + k), '0);
      mst_addr[1*AW +: AW]       = 12'h200;
      mst_addr[2*AW +: AW]       = 12'h300;
      mst_write_data[2*DW +: DW] = 32'h0000CAFE;
      push_cmd(1'b1, 12'h300, 32'h0000CAFE, 3'b100);
      mst_read[1]  = 1'b1;
      mst_write[2] = 1'b1;
      tick(1);
      chk("full_write_ack", 128'(mst_ack), 128'(3'b100));
      mst_write[2] = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick(1);
         chk("full_read_stalled", 128'(av_read), 128'(0));
      end
      push_rsp(3'b001, 32'h55);
      push_cmd(1'b0, 12'h200, '0, 3'b010);
      av_rd_data_valid = 1'b1;
      av_read_data     = 32'h55;
      tick(1);
      chk("full_pop_push_ack", 128'(mst_ack),           128'(3'b010));
      chk("full_pop_rsp",      128'(mst_rd_data_valid), 128'(3'b001));
      av_rd_data_valid = 1'b0;
      mst_read[1]      = 1'b0;
      tick(1);
      for (int k = 0; k < 4; k++) begin
         push_rsp((k < 3) ? 3'b001 : 3'b010, DW'(32'h56 + k));
         av_rd_data_valid = 1'b1;
         av_read_data     = DW'(32'h56 + k);
         tick(1);
      end
      av_rd_data_valid = 1'b0;
      tick(2);

      // Underflow: response with nothing outstanding
      chk("err_clear_before", 128'(rd_underflow_err), 128'(0));
      av_rd_data_valid = 1'b1;
      av_read_data     = 32'h99;
      tick(1);
      av_rd_data_valid = 1'b0;
      chk("uf_no_rsp", 128'(mst_rd_data_valid), 128'(0));
      chk("uf_err",    128'(rd_underflow_err),  128'(1));
      tick(3);
      chk("uf_err_sticky", 128'(rd_underflow_err), 128'(1));

      // Reset with two reads outstanding; late responses are underflows
      apply_reset();
      do_cmd(0, 1'b0, 12'h040, '0);
      do_cmd(1, 1'b0, 12'h044, '0);
      tick(1);
      apply_reset();
      av_rd_data_valid = 1'b1;
      av_read_data     = 32'hAA;
      tick(1);
      av_read_data     = 32'hBB;
      tick(1);
      av_rd_data_valid = 1'b0;
      chk("post_rst_no_rsp", 128'(mst_rd_data_valid), 128'(0));
      tick(1);
      chk("post_rst_err", 128'(rd_underflow_err), 128'(1));
      set_all_req_data();
      push_cmd(1'b1, 12'h020, 32'hA000_0000, 3'b001);
      mst_write = 3'b111;
      tick(1);
      chk("post_rst_first_grant", 128'(mst_ack), 128'(3'b001));
      mst_write = '0;
      tick(3);

      chk("cmd_q_drained", 128'(cmd_q.size()), 128'(0));
      chk("rsp_q_drained", 128'(rsp_q.size()), 128'(0));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
